// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage: FSM state encoding,
// write-back source encodings and default datapath widths.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int PC_W       = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Write-back source select as produced by decode; passed through untouched here.
  localparam logic [1:0] REGSRC_ALU = 2'd0;
  localparam logic [1:0] REGSRC_MEM = 2'd1;
  localparam logic [1:0] REGSRC_PC  = 2'd2;
  localparam logic [1:0] REGSRC_WB  = 2'd3;

endpackage

// File: rtl/mem_ack_timer.sv
// Saturating wait counter for an outstanding memory request. expired is
// asserted in the cycle whose count step would reach ACK_TIMEOUT; 0 disables it.
module mem_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ACK_TIMEOUT);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  generate
    if (ACK_TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = enable && (cnt_reg == (LIMIT - 1'b1));
    end
  endgenerate

endmodule

// File: rtl/memory_stage.sv
// EX/MEM pipeline register plus data-memory req/ack sequencer and halt latch.
// Optional MEM_ALIGN_CHECK_EN rejects odd memory addresses with err instead of accessing.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] alu_in,
  input  logic [DATA_W-1:0] srcb_in,
  input  logic [15:0]       next_pc_in,
  input  logic [DATA_W-1:0] wb_in,
  input  logic [1:0]        regsrc_in,
  input  logic              memread_in,
  input  logic              memwrt_in,
  input  logic              dmp_in,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] alu_out,
  output logic [15:0]       next_pc_out,
  output logic [DATA_W-1:0] wb_out,
  output logic [1:0]        regsrc_out,
  output logic              halt,
  output logic              err
);

  state_t state_reg;
  logic   accept;
  logic   is_mem_op;
  logic   timer_clear;
  logic   timer_enable;
  logic   timer_expired;

  assign ex_ready  = (state_reg == IDLE);
  assign accept    = ex_valid && ex_ready;
  assign is_mem_op = memread_in || memwrt_in;
  // The captured ALU result doubles as the address, so it stays stable for the whole access.
  assign mem_addr  = alu_out;

  assign timer_clear  = accept && !dmp_in && is_mem_op;
  assign timer_enable = (state_reg == ACCESS) && !mem_ack;

  mem_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      rdata_out   <= '0;
      alu_out     <= '0;
      next_pc_out <= '0;
      wb_out      <= '0;
      regsrc_out  <= '0;
      halt        <= 1'b0;
      err         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            alu_out     <= alu_in;
            next_pc_out <= next_pc_in;
            wb_out      <= wb_in;
            regsrc_out  <= regsrc_in;
            rdata_out   <= '0;
            if (dmp_in) begin
              state_reg <= HALTED;
              halt      <= 1'b1;
              wb_valid  <= 1'b1;
            end else if (is_mem_op) begin
`ifdef MEM_ALIGN_CHECK_EN
              if (alu_in[0]) begin
                wb_valid <= 1'b1;
                err      <= 1'b1;
              end else begin
                state_reg <= ACCESS;
                mem_req   <= 1'b1;
                mem_wr    <= memwrt_in;
                mem_wdata <= srcb_in;
              end
`else
              state_reg <= ACCESS;
              mem_req   <= 1'b1;
              // A load+store encoding resolves to a store.
              mem_wr    <= memwrt_in;
              mem_wdata <= srcb_in;
`endif
            end else begin
              wb_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // An ack in the expiry cycle takes precedence over the abort.
          if (mem_ack) begin
            if (!mem_wr) begin
              rdata_out <= mem_rdata;
            end
            mem_req   <= 1'b0;
            wb_valid  <= 1'b1;
            state_reg <= IDLE;
          end else if (timer_expired) begin
            mem_req   <= 1'b0;
            rdata_out <= '0;
            wb_valid  <= 1'b1;
            err       <= 1'b1;
            state_reg <= IDLE;
          end
        end
        HALTED: begin
          mem_req <= 1'b0;
          halt    <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (ACK_TIMEOUT=4); one task per scenario,
// inputs driven and outputs checked on the falling clock edge.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] alu_in;
  logic [15:0] srcb_in;
  logic [15:0] next_pc_in;
  logic [15:0] wb_in;
  logic [1:0]  regsrc_in;
  logic        memread_in;
  logic        memwrt_in;
  logic        dmp_in;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [15:0] rdata_out;
  logic [15:0] alu_out;
  logic [15:0] next_pc_out;
  logic [15:0] wb_out;
  logic [1:0]  regsrc_out;
  logic        halt;
  logic        err;

  int total = 0;
  int bad   = 0;

  memory_stage #(
    .DATA_W(16),
    .ADDR_W(16),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_in(alu_in), .srcb_in(srcb_in), .next_pc_in(next_pc_in), .wb_in(wb_in),
    .regsrc_in(regsrc_in), .memread_in(memread_in), .memwrt_in(memwrt_in), .dmp_in(dmp_in),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .rdata_out(rdata_out),
    .alu_out(alu_out), .next_pc_out(next_pc_out), .wb_out(wb_out), .regsrc_out(regsrc_out),
    .halt(halt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ex_valid = 1'b0; alu_in = '0; srcb_in = '0; next_pc_in = '0; wb_in = '0;
    regsrc_in = '0; memread_in = 1'b0; memwrt_in = 1'b0; dmp_in = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic rd,
                         input logic wr, input logic dmp);
    ex_valid = 1'b1; alu_in = a; srcb_in = b; memread_in = rd; memwrt_in = wr; dmp_in = dmp;
    next_pc_in = a + 16'd2; wb_in = ~a; regsrc_in = a[1:0];
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready got=%0b exp=1", ex_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
    total++; if (halt !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_halt_err got=%0b%0b exp=00", halt, err); end
    total++; if (alu_out !== 16'h0 || rdata_out !== 16'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0000/0000", alu_out, rdata_out); end
    $display("reset: ex_ready=%0b mem_req=%0b halt=%0b", ex_ready, mem_req, halt);
  endtask

  task automatic test_alu_op();
    send_op(16'h1234, 16'h9999, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid got=%0b exp=1", wb_valid); end
    total++; if (alu_out !== 16'h1234) begin bad++; $display("FAIL alu_out got=%h exp=1234", alu_out); end
    total++; if (rdata_out !== 16'h0) begin bad++; $display("FAIL alu_rdata got=%h exp=0000", rdata_out); end
    total++; if (next_pc_out !== 16'h1236 || wb_out !== 16'hEDCB || regsrc_out !== 2'd0)
      begin bad++; $display("FAIL alu_passthru got=%h/%h/%0d exp=1236/edcb/0", next_pc_out, wb_out, regsrc_out); end
    total++; if (mem_req !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL alu_req_err got=%0b%0b exp=00", mem_req, err); end
    $display("alu: alu_out=%h wb_valid=%0b", alu_out, wb_valid);
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%0b exp=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    send_op(16'h0101, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (wb_valid !== 1'b1 || alu_out !== 16'h0101) begin bad++; $display("FAIL b2b_first got=%0b/%h exp=1/0101", wb_valid, alu_out); end
    send_op(16'h0202, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || alu_out !== 16'h0202) begin bad++; $display("FAIL b2b_second got=%0b/%h exp=1/0202", wb_valid, alu_out); end
    $display("back_to_back: alu_out=%h", alu_out);
    @(negedge clk);
  endtask

  task automatic test_load();
    int low_cnt = 0;
    send_op(16'h0040, 16'h7777, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle_inputs();
      if (ex_ready === 1'b0) low_cnt++;
      total++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0040)
        begin bad++; $display("FAIL load_req_c%0d got=%0b/%0b/%h exp=1/0/0040", k, mem_req, mem_wr, mem_addr); end
      // Ack on the 4th request cycle: same cycle the 4-cycle timer would expire.
      if (k == 4) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
    end
    // Accept an ALU op in the write-back cycle of the load.
    @(negedge clk);
    idle_inputs();
    if (ex_ready === 1'b0) low_cnt++;
    total++; if (low_cnt != 4) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=4", low_cnt); end
    total++; if (wb_valid !== 1'b1 || rdata_out !== 16'hBEEF) begin bad++; $display("FAIL load_result got=%0b/%h exp=1/beef", wb_valid, rdata_out); end
    total++; if (mem_req !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL load_end got=%0b/%0b exp=0/0", mem_req, err); end
    $display("load: rdata_out=%h stall=%0d", rdata_out, low_cnt);
    send_op(16'h0300, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || alu_out !== 16'h0300 || rdata_out !== 16'h0)
      begin bad++; $display("FAIL load_follow got=%0b/%h/%h exp=1/0300/0000", wb_valid, alu_out, rdata_out); end
    @(negedge clk);
  endtask

  task automatic test_store(input logic [15:0] addr, input logic [15:0] data, input logic also_rd);
    send_op(addr, data, also_rd, 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    total++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== addr || mem_wdata !== data)
      begin bad++; $display("FAIL store_req got=%0b/%0b/%h/%h exp=1/1/%h/%h", mem_req, mem_wr, mem_addr, mem_wdata, addr, data); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_wdata !== data) begin bad++; $display("FAIL store_hold got=%0b/%h exp=1/%h", mem_req, mem_wdata, data); end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || rdata_out !== 16'h0 || err !== 1'b0 || mem_req !== 1'b0)
      begin bad++; $display("FAIL store_done got=%0b/%h/%0b/%0b exp=1/0000/0/0", wb_valid, rdata_out, err, mem_req); end
    $display("store: addr=%h data=%h rd=%0b", addr, data, also_rd);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    send_op(16'h0080, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle_inputs();
      if (mem_req === 1'b1) req_cnt++;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL timeout_early_c%0d got=%0b exp=0", k, wb_valid); end
    end
    total++; if (req_cnt != 4) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=4", req_cnt); end
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b1 || err !== 1'b1 || rdata_out !== 16'h0)
      begin bad++; $display("FAIL timeout_abort got=%0b/%0b/%0b/%h exp=0/1/1/0000", mem_req, wb_valid, err, rdata_out); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL timeout_idle got=%0b exp=1", ex_ready); end
    $display("timeout: req_cycles=%0d err=%0b", req_cnt, err);
    @(negedge clk);
    total++; if (err !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%0b/%0b exp=0/0", err, wb_valid); end
  endtask

  task automatic test_align();
    send_op(16'h0003, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
`ifdef MEM_ALIGN_CHECK_EN
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b1 || err !== 1'b1 || rdata_out !== 16'h0 || ex_ready !== 1'b1)
      begin bad++; $display("FAIL align_reject got=%0b/%0b/%0b/%h/%0b exp=0/1/1/0000/1", mem_req, wb_valid, err, rdata_out, ex_ready); end
    @(negedge clk);
`else
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0003) begin bad++; $display("FAIL align_odd_req got=%0b/%h exp=1/0003", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    idle_inputs();
    total++; if (wb_valid !== 1'b1 || err !== 1'b0 || rdata_out !== 16'h5A5A)
      begin bad++; $display("FAIL align_odd_done got=%0b/%0b/%h exp=1/0/5a5a", wb_valid, err, rdata_out); end
    @(negedge clk);
`endif
    $display("align: odd address load handled");
  endtask

  task automatic test_reset_mid_access();
    int wb_seen = 0;
    send_op(16'h0044, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%0b exp=1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_async got=%0b exp=0", mem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) wb_seen++;
      mem_ack = 1'b0;
    end
    total++; if (wb_seen != 0 || ex_ready !== 1'b1 || mem_req !== 1'b0)
      begin bad++; $display("FAIL rst_mid_after got=%0d/%0b/%0b exp=0/1/0", wb_seen, ex_ready, mem_req); end
    $display("reset_mid_access: wb_pulses=%0d", wb_seen);
    idle_inputs();
  endtask

  task automatic test_halt();
    send_op(16'h0DDD, 16'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    total++; if (halt !== 1'b1 || wb_valid !== 1'b1 || alu_out !== 16'h0DDD || ex_ready !== 1'b0)
      begin bad++; $display("FAIL halt_enter got=%0b/%0b/%h/%0b exp=1/1/0ddd/0", halt, wb_valid, alu_out, ex_ready); end
    send_op(16'h1110, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (ex_ready !== 1'b0 || wb_valid !== 1'b0 || halt !== 1'b1 || mem_req !== 1'b0 || alu_out !== 16'h0DDD)
        begin bad++; $display("FAIL halt_hold_c%0d got=%0b/%0b/%0b/%0b/%h exp=0/0/1/0/0ddd", k, ex_ready, wb_valid, halt, mem_req, alu_out); end
    end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (halt !== 1'b0 || ex_ready !== 1'b1) begin bad++; $display("FAIL halt_cleared got=%0b/%0b exp=0/1", halt, ex_ready); end
    $display("halt: sticky until reset");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_load();
    test_store(16'h0010, 16'h00AA, 1'b0);
    test_store(16'h0020, 16'h0055, 1'b1);
    test_timeout();
    test_align();
    test_reset_mid_access();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
